// File: rtl/serial_byte_rx.sv
// serial_byte_rx: asynchronous serial receiver (8N1, or 8E1 when SERIAL_RX_PARITY_EN is defined)
// with a one-deep holding register, a one-cycle frame_err pulse and a sticky overrun flag.
module serial_byte_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 hz100,
    input  logic                 reset_n,
    input  logic                 rxd,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] rxdata,
    output logic                 rxready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_WAITHI = 3'd4
`ifdef SERIAL_RX_PARITY_EN
        , ST_PARITY = 3'd5
`endif
    } state_e;

    // Whole FSM context in one struct so a checker can bind to r_fsm directly.
    typedef struct packed {
        state_e          state;
        logic [CW-1:0]   count;
        logic [IW-1:0]   bitidx;
    } fsm_t;

    logic [1:0]           r_sync;
    fsm_t                 r_fsm;
    fsm_t                 w_fsm_nxt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_deliver;
    logic                 r_frame_err;
    logic [DATA_BITS-1:0] r_rxdata;
    logic                 r_rxready;
    logic                 r_overrun;

    logic w_rxs;
    logic w_data_smp;
    logic w_stop_smp;
    logic w_par_bad;
    logic w_frame_good;
    logic w_frame_bad;

    assign w_rxs = r_sync[1];

    always_ff @(posedge hz100 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rxd};
        end
    end

    // FSM process 1: state register
    always_ff @(posedge hz100 or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm <= '{state: ST_IDLE, count: '0, bitidx: '0};
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM process 2: next state
    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_fsm_nxt.count = r_fsm.count + 1'b1;
        case (r_fsm.state)
            ST_IDLE: begin
                w_fsm_nxt.count = '0;
                if (!w_rxs) begin
                    w_fsm_nxt.state = ST_START;
                end
            end
            ST_START: begin
                if (r_fsm.count == CNT_MID) begin
                    w_fsm_nxt.count  = '0;
                    w_fsm_nxt.bitidx = '0;
                    w_fsm_nxt.state  = w_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_fsm.count == CNT_LAST) begin
                    w_fsm_nxt.count  = '0;
                    w_fsm_nxt.bitidx = r_fsm.bitidx + 1'b1;
                    if (r_fsm.bitidx == IDX_LAST) begin
                        w_fsm_nxt.bitidx = '0;
`ifdef SERIAL_RX_PARITY_EN
                        w_fsm_nxt.state  = ST_PARITY;
`else
                        w_fsm_nxt.state  = ST_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: begin
                if (r_fsm.count == CNT_LAST) begin
                    w_fsm_nxt.count = '0;
                    w_fsm_nxt.state = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (r_fsm.count == CNT_LAST) begin
                    w_fsm_nxt.count = '0;
                    w_fsm_nxt.state = w_frame_good ? ST_IDLE : ST_WAITHI;
                end
            end
            ST_WAITHI: begin
                w_fsm_nxt.count = '0;
                if (w_rxs) begin
                    w_fsm_nxt.state = ST_IDLE;
                end
            end
            default: begin
                w_fsm_nxt.state  = ST_IDLE;
                w_fsm_nxt.count  = '0;
                w_fsm_nxt.bitidx = '0;
            end
        endcase
    end

    // FSM process 3: sample strobes and frame verdict
    always_comb begin
        w_data_smp   = (r_fsm.state == ST_DATA) && (r_fsm.count == CNT_LAST);
        w_stop_smp   = (r_fsm.state == ST_STOP) && (r_fsm.count == CNT_LAST);
        w_frame_good = w_stop_smp && w_rxs && !w_par_bad;
        w_frame_bad  = w_stop_smp && !(w_rxs && !w_par_bad);
    end

`ifdef SERIAL_RX_PARITY_EN
    logic r_par_err;
    logic w_par_smp;

    assign w_par_smp = (r_fsm.state == ST_PARITY) && (r_fsm.count == CNT_LAST);
    assign w_par_bad = r_par_err;

    // Even parity: the received bit must equal the XOR of the data bits.
    always_ff @(posedge hz100 or negedge reset_n) begin
        if (!reset_n) begin
            r_par_err <= 1'b0;
        end else if (w_par_smp) begin
            r_par_err <= w_rxs ^ (^r_shreg);
        end
    end
`else
    assign w_par_bad = 1'b0;
`endif

    // Consumer handshake: rxready=1 means rxdata holds an unread byte; ack=1 while
    // rxready=1 pops it on the next edge. A byte arriving with rxready still high and
    // no ack in that same cycle is dropped and sets overrun until the next pop.
    always_ff @(posedge hz100 or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg     <= '0;
            r_deliver   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rxdata    <= '0;
            r_rxready   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_deliver   <= w_frame_good;
            r_frame_err <= w_frame_bad;
            if (w_data_smp) begin
                r_shreg <= {w_rxs, r_shreg[DATA_BITS-1:1]};
            end
            if (r_deliver) begin
                if (!r_rxready || ack) begin
                    r_rxdata  <= r_shreg;
                    r_rxready <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (ack && r_rxready) begin
                r_rxready <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign rxdata    = r_rxdata;
    assign rxready   = r_rxready;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx: directed frames into serial_byte_rx at 16 clocks per bit, checked against
// hand-computed bytes, flags and latency.
`timescale 1ns/1ps
module tb_serial_byte_rx;

    localparam int CPB = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Latency in edges, counted from the first edge that sees the low start bit.
    localparam int LAT_SPEC   = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB;
    // Edges after the drive negedge at which the byte is delivered (the rxready-raising edge).
    localparam int DELIV_EDGE = LAT_SPEC + 2;

    logic       hz100   = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd     = 1'b1;
    logic       ack     = 1'b0;
    logic [7:0] rxdata;
    logic       rxready;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_rise = 0;
    int n_ferr_pulse = 0;
    int n_ferr_cyc = 0;
    int last_rise_cyc = 0;
    logic prev_rdy = 1'b0;
    logic prev_ferr = 1'b0;
    logic [7:0] exp_q[$];
`ifdef SERIAL_RX_PARITY_EN
    logic bad_par = 1'b0;
`endif

    serial_byte_rx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
        .hz100    (hz100),
        .reset_n  (reset_n),
        .rxd      (rxd),
        .ack      (ack),
        .rxdata   (rxdata),
        .rxready  (rxready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    // Clock and cycle counter
    always #5 hz100 = ~hz100;
    always @(posedge hz100) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge hz100) begin
        if (rxready && !prev_rdy) begin
            n_rise++;
            last_rise_cyc = cyc;
        end
        if (frame_err) n_ferr_cyc++;
        if (frame_err && !prev_ferr) n_ferr_pulse++;
        prev_rdy  = rxready;
        prev_ferr = frame_err;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare rxdata against the oldest expected byte
    task automatic check_rx(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, {24'd0, rxdata}, {24'd0, e});
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge hz100);
    endtask

    // Drives one frame starting at the current negedge; line left high afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
        rxd = 1'b0;
        repeat (CPB) @(negedge hz100);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge hz100);
        end
`ifdef SERIAL_RX_PARITY_EN
        rxd = (^b) ^ bad_par;
        repeat (CPB) @(negedge hz100);
`endif
        rxd = stop_val;
        repeat (stop_len) @(negedge hz100);
        rxd = 1'b1;
    endtask

    task automatic pop_ack();
        ack = 1'b1;
        @(negedge hz100);
        ack = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1);
    end

    initial begin
        int c;
        int lat;
        int r0;
        int f0;
        int fc0;

        reset_n = 1'b0;
        repeat (3) @(negedge hz100);
        check_eq("rst_rxready", rxready, 0);
        check_eq("rst_rxdata", rxdata, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        idle(4);

        // 1: 0xA5, latency and ack
        c = cyc;
        r0 = n_rise;
        f0 = n_ferr_pulse;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, CPB);
        lat = last_rise_cyc - (c + 1);
        check_eq("t1_rise_count", n_rise - r0, 1);
        check_eq("t1_latency_window", (lat >= LAT_SPEC - 1) && (lat <= LAT_SPEC + 1), 1);
        check_rx("t1_rxdata");
        check_eq("t1_frame_err", n_ferr_pulse - f0, 0);
        check_eq("t1_overrun", overrun, 0);
        pop_ack();
        check_eq("t1_ack_clears", rxready, 0);
        idle(CPB);

        // 2: short low glitch is rejected, then 0x3C
        r0 = n_rise;
        f0 = n_ferr_pulse;
        rxd = 1'b0;
        repeat (4) @(negedge hz100);
        idle(3 * CPB);
        check_eq("t2_glitch_no_rdy", n_rise - r0, 0);
        check_eq("t2_glitch_no_ferr", n_ferr_pulse - f0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, CPB);
        check_rx("t2_rxdata");
        pop_ack();
        idle(CPB);

        // 3: 0x81 with stop held low for 3 bit times -> one frame_err, then 0x42
        r0 = n_rise;
        f0 = n_ferr_pulse;
        fc0 = n_ferr_cyc;
        send_frame(8'h81, 1'b0, 3 * CPB);
        idle(2 * CPB);
        check_eq("t3_ferr_pulses", n_ferr_pulse - f0, 1);
        check_eq("t3_ferr_cycles", n_ferr_cyc - fc0, 1);
        check_eq("t3_no_rdy", n_rise - r0, 0);
        check_eq("t3_rxready", rxready, 0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, CPB);
        check_rx("t3_rxdata");
        pop_ack();
        idle(CPB);

        // 4: 0x11 then 0x22 back-to-back, no ack -> overrun
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, CPB);
        send_frame(8'h22, 1'b1, CPB);
        idle(4);
        check_rx("t4_rxdata_kept");
        check_eq("t4_overrun_set", overrun, 1);
        check_eq("t4_rxready", rxready, 1);
        pop_ack();
        check_eq("t4_ack_rxready", rxready, 0);
        check_eq("t4_ack_overrun", overrun, 0);
        idle(CPB);

        // 5: ack on the exact deliver edge of 0x22 while 0x11 is pending
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, CPB);
        check_rx("t5_first");
        r0 = n_rise;
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1, CPB);
            begin
                repeat (DELIV_EDGE - 1) @(negedge hz100);
                ack = 1'b1;
                @(negedge hz100);
                ack = 1'b0;
            end
        join
        idle(2);
        check_rx("t5_rxdata_replaced");
        check_eq("t5_rxready_held", rxready, 1);
        check_eq("t5_overrun", overrun, 0);
        check_eq("t5_no_new_rise", n_rise - r0, 0);
        pop_ack();
        idle(CPB);

        // 6: reset in the middle of 0xFF with a byte pending and overrun set
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, CPB);
        send_frame(8'h44, 1'b1, CPB);
        check_rx("t6_pending");
        check_eq("t6_overrun_before", overrun, 1);
        fork
            send_frame(8'hFF, 1'b1, CPB);
            begin
                repeat (4 * CPB) @(negedge hz100);
                reset_n = 1'b0;
                #2;
                check_eq("t6_rst_rxready", rxready, 0);
                check_eq("t6_rst_rxdata", rxdata, 0);
                check_eq("t6_rst_overrun", overrun, 0);
                check_eq("t6_rst_frame_err", frame_err, 0);
            end
        join
        idle(2);
        f0 = n_ferr_pulse;
        reset_n = 1'b1;
        idle(2 * CPB);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, CPB);
        check_rx("t6_rxdata_after");
        check_eq("t6_no_ferr", n_ferr_pulse - f0, 0);
        pop_ack();
        idle(CPB);

`ifdef SERIAL_RX_PARITY_EN
        // 7: wrong parity on 0x07 -> frame_err, no byte
        r0 = n_rise;
        f0 = n_ferr_pulse;
        bad_par = 1'b1;
        send_frame(8'h07, 1'b1, CPB);
        bad_par = 1'b0;
        idle(CPB);
        check_eq("t7_par_ferr", n_ferr_pulse - f0, 1);
        check_eq("t7_par_no_rdy", n_rise - r0, 0);
        check_eq("t7_rxready", rxready, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
